apb_gpio_ctrl: RTL

//  Parametrised APB GPIO port: NBITS pads with per-pin direction.

---
 rtl/apb_gpio_pkg.sv | 93 +++++++++
 rtl/gpio_in_filter.sv | 82 ++++++++
 rtl/apb_gpio_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/apb_gpio_pkg.sv
// Shared definitions for the APB GPIO block: register offsets, alias ops, decode.
// Latency: combinational helpers only.
// Backpressure: none (helpers only).
//
// apply_op() folds the atomic OR/AND/XOR alias windows into one update path.
// decode_addr() maps a word-aligned byte offset to a target register and op.
package apb_gpio_pkg;

    // Base register map
    localparam logic [7:0] OFF_DATA  = 8'h00;
    localparam logic [7:0] OFF_OUT   = 8'h04;
    localparam logic [7:0] OFF_DIR   = 8'h08;
    localparam logic [7:0] OFF_IMASK = 8'h0C;
    localparam logic [7:0] OFF_IPOL  = 8'h10;
    localparam logic [7:0] OFF_IEDGE = 8'h14;
    localparam logic [7:0] OFF_IFLAG = 8'h18;
    localparam logic [7:0] OFF_DBCNT = 8'h1C;

    // Atomic alias windows onto OUT / DIR / IMASK
    localparam logic [7:0] OFF_OR_OUT    = 8'h54;
    localparam logic [7:0] OFF_OR_DIR    = 8'h58;
    localparam logic [7:0] OFF_OR_IMASK  = 8'h5C;
    localparam logic [7:0] OFF_AND_OUT   = 8'h64;
    localparam logic [7:0] OFF_AND_DIR   = 8'h68;
    localparam logic [7:0] OFF_AND_IMASK = 8'h6C;
    localparam logic [7:0] OFF_XOR_OUT   = 8'h74;
    localparam logic [7:0] OFF_XOR_DIR   = 8'h78;
    localparam logic [7:0] OFF_XOR_IMASK = 8'h7C;

    typedef enum logic [1:0] {
        OP_WR  = 2'd0,
        OP_OR  = 2'd1,
        OP_AND = 2'd2,
        OP_XOR = 2'd3
    } alias_op_e;

    typedef enum logic [3:0] {
        SEL_NONE  = 4'd0,
        SEL_DATA  = 4'd1,
        SEL_OUT   = 4'd2,
        SEL_DIR   = 4'd3,
        SEL_IMASK = 4'd4,
        SEL_IPOL  = 4'd5,
        SEL_IEDGE = 4'd6,
        SEL_IFLAG = 4'd7,
        SEL_DBCNT = 4'd8
    } reg_sel_e;

    typedef struct packed {
        reg_sel_e  sel;
        alias_op_e op;
    } reg_dec_t;

    function automatic logic [31:0] apply_op(input logic [31:0] old,
                                             input logic [31:0] wdata,
                                             input alias_op_e   op);
        case (op)
            OP_OR:   return old | wdata;
            OP_AND:  return old & wdata;
            OP_XOR:  return old ^ wdata;
            default: return wdata;
        endcase
    endfunction

    // off must already have bits [1:0] cleared
    function automatic reg_dec_t decode_addr(input logic [7:0] off);
        reg_dec_t d;
        d.sel = SEL_NONE;
        d.op  = OP_WR;
        case (off)
            OFF_DATA:      d.sel = SEL_DATA;
            OFF_OUT:       d.sel = SEL_OUT;
            OFF_DIR:       d.sel = SEL_DIR;
            OFF_IMASK:     d.sel = SEL_IMASK;
            OFF_IPOL:      d.sel = SEL_IPOL;
            OFF_IEDGE:     d.sel = SEL_IEDGE;
            OFF_IFLAG:     d.sel = SEL_IFLAG;
            OFF_DBCNT:     d.sel = SEL_DBCNT;
            OFF_OR_OUT:    begin d.sel = SEL_OUT;   d.op = OP_OR;  end
            OFF_OR_DIR:    begin d.sel = SEL_DIR;   d.op = OP_OR;  end
            OFF_OR_IMASK:  begin d.sel = SEL_IMASK; d.op = OP_OR;  end
            OFF_AND_OUT:   begin d.sel = SEL_OUT;   d.op = OP_AND; end
            OFF_AND_DIR:   begin d.sel = SEL_DIR;   d.op = OP_AND; end
            OFF_AND_IMASK: begin d.sel = SEL_IMASK; d.op = OP_AND; end
            OFF_XOR_OUT:   begin d.sel = SEL_OUT;   d.op = OP_XOR; end
            OFF_XOR_DIR:   begin d.sel = SEL_DIR;   d.op = OP_XOR; end
            OFF_XOR_IMASK: begin d.sel = SEL_IMASK; d.op = OP_XOR; end
            default:       d.sel = SEL_NONE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/gpio_in_filter.sv
// Per-pin input conditioning: 2-flop synchroniser, optional debounce, edge detect.
// Latency: pad change reaches filt after 2 clk edges (debounce bypassed or DBCNT=0).
// Backpressure: none; free-running.
//
// Ports: clk, rstn (async active-low), din (asynchronous pad), dbcnt (debounce
//        threshold), filt (conditioned level), rise/fall (one-cycle pulses).
// Optional feature macro: APB_GPIO_DEBOUNCE_EN enables the DBW-bit debounce counter.
module gpio_in_filter
    import apb_gpio_pkg::*;
#(
    parameter int DBW = 8
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           din,
    input  logic [DBW-1:0] dbcnt,
    output logic           filt,
    output logic           rise,
    output logic           fall
);

    logic sync1;
    logic sync2;
    logic filt_prev;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

`ifdef APB_GPIO_DEBOUNCE_EN
    logic           filt_q;
    logic [DBW-1:0] cnt;

    // cnt holds the number of consecutive cycles sync2 has disagreed with
    // filt_q; the new level is accepted on the (dbcnt+1)-th such cycle.
    // Any cycle of agreement (a bounce back) restarts the count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            filt_q <= 1'b0;
            cnt    <= '0;
        end else if (dbcnt == '0) begin
            // keep filt_q tracking so enabling debounce later starts clean
            filt_q <= sync2;
            cnt    <= '0;
        end else if (sync2 != filt_q) begin
            if (cnt == dbcnt) begin
                filt_q <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + DBW'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

    // DBCNT=0 is a true bypass so latency matches the non-debounce build
    assign filt = (dbcnt == '0) ? sync2 : filt_q;
`else
    logic unused_dbcnt;
    assign unused_dbcnt = ^dbcnt;
    assign filt         = sync2;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            filt_prev <= 1'b0;
        end else begin
            filt_prev <= filt;
        end
    end

    assign rise = filt & ~filt_prev;
    assign fall = ~filt & filt_prev;

endmodule

// File: rtl/apb_gpio_ctrl.sv
// APB GPIO port: NBITS pads, per-pin direction, atomic aliases, edge/level IRQs.
// Latency: writes land on pads 1 cycle after commit; pad input visible in DATA after 2 edges; irq +1 after IFLAG.
// Backpressure: none; pready tied high, zero wait states.
//
// Ports: clk, rstn (async active-low); APB slave apb_psel/penable/pwrite/paddr/
//        pwdata/prdata/pready/pslverr; gpio_din (async pads), gpio_dout,
//        gpio_oen (OEPOL selects enable polarity); irq (registered OR of IFLAG).
// Optional feature macro: APB_GPIO_DEBOUNCE_EN (per-pin debounce, DBCNT register
// live). Without it DBCNT reads 0 and ignores writes.
module apb_gpio_ctrl
    import apb_gpio_pkg::*;
#(
    parameter int NBITS  = 8,
    parameter bit OEPOL  = 1'b0,
    parameter int DBW    = 8,
    parameter int DB_RST = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             apb_psel,
    input  logic             apb_penable,
    input  logic             apb_pwrite,
    input  logic [7:0]       apb_paddr,
    input  logic [31:0]      apb_pwdata,
    output logic [31:0]      apb_prdata,
    output logic             apb_pready,
    output logic             apb_pslverr,
    input  logic [NBITS-1:0] gpio_din,
    output logic [NBITS-1:0] gpio_dout,
    output logic [NBITS-1:0] gpio_oen,
    output logic             irq
);

    localparam logic [DBW-1:0] DB_RST_V = DBW'(DB_RST);

    // Register state
    logic [NBITS-1:0] out_q;
    logic [NBITS-1:0] dir_q;
    logic [NBITS-1:0] imask_q;
    logic [NBITS-1:0] ipol_q;
    logic [NBITS-1:0] iedge_q;
    logic [NBITS-1:0] iflag_q;
    logic [DBW-1:0]   dbcnt_q;
    logic             irq_q;

    // Bus decode
    reg_dec_t         dec;
    logic             access;
    logic             mapped;
    logic             wr_en;
    logic [NBITS-1:0] wdat_n;
    logic             unused_paddr;

    // Next-state and input path
    logic [NBITS-1:0] out_nxt;
    logic [NBITS-1:0] dir_nxt;
    logic [NBITS-1:0] imask_nxt;
    logic [NBITS-1:0] iflag_nxt;
    logic [NBITS-1:0] w1c;
    logic [NBITS-1:0] filt;
    logic [NBITS-1:0] rise;
    logic [NBITS-1:0] fall;
    logic [NBITS-1:0] evt;
    logic [31:0]      rdata;

    assign dec          = decode_addr({apb_paddr[7:2], 2'b00});
    assign unused_paddr = ^apb_paddr[1:0];
    assign access       = apb_psel & apb_penable;
    assign mapped       = (dec.sel != SEL_NONE);
    assign wr_en        = access & apb_pwrite & mapped;
    // register bits at or above NBITS do not exist, so upper write data drops here
    assign wdat_n       = apb_pwdata[NBITS-1:0];

    // ------------------------------------------------------------------
    // Input conditioning, one instance per pin
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NBITS; i++) begin : g_pin
        gpio_in_filter #(
            .DBW (DBW)
        ) u_filt (
            .clk   (clk),
            .rstn  (rstn),
            .din   (gpio_din[i]),
            .dbcnt (dbcnt_q),
            .filt  (filt[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

    // ------------------------------------------------------------------
    // Interrupt events: edge pins fire on the IPOL-selected transition,
    // level pins fire every cycle the filtered input equals IPOL.
    // Output pins are sampled too, so a pin can interrupt on its own drive.
    // ------------------------------------------------------------------
    assign evt = imask_q & ( (iedge_q & ((ipol_q & rise) | (~ipol_q & fall)))
                           | (~iedge_q & ~(filt ^ ipol_q)) );

    assign w1c = (wr_en && dec.sel == SEL_IFLAG) ? wdat_n : '0;

    // A new event wins over a same-cycle clear so no edge is ever lost.
    assign iflag_nxt = (iflag_q & ~w1c) | evt;

    // ------------------------------------------------------------------
    // OUT / DIR / IMASK share the alias path: plain write or atomic op
    // ------------------------------------------------------------------
    always_comb begin
        out_nxt   = out_q;
        dir_nxt   = dir_q;
        imask_nxt = imask_q;
        if (wr_en) begin
            case (dec.sel)
                SEL_OUT:   out_nxt   = NBITS'(apply_op(32'(out_q),   apb_pwdata, dec.op));
                SEL_DIR:   dir_nxt   = NBITS'(apply_op(32'(dir_q),   apb_pwdata, dec.op));
                SEL_IMASK: imask_nxt = NBITS'(apply_op(32'(imask_q), apb_pwdata, dec.op));
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_q   <= '0;
            dir_q   <= '0;
            imask_q <= '0;
            ipol_q  <= '0;
            iedge_q <= '0;
            iflag_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            out_q   <= out_nxt;
            dir_q   <= dir_nxt;
            imask_q <= imask_nxt;
            iflag_q <= iflag_nxt;
            irq_q   <= |iflag_q;
            if (wr_en && dec.sel == SEL_IPOL) begin
                ipol_q <= wdat_n;
            end
            if (wr_en && dec.sel == SEL_IEDGE) begin
                iedge_q <= wdat_n;
            end
        end
    end

`ifdef APB_GPIO_DEBOUNCE_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dbcnt_q <= DB_RST_V;
        end else if (wr_en && dec.sel == SEL_DBCNT) begin
            dbcnt_q <= apb_pwdata[DBW-1:0];
        end
    end
`else
    logic unused_db;
    assign unused_db = ^DB_RST_V;
    assign dbcnt_q   = '0;
`endif

    // ------------------------------------------------------------------
    // Read mux; aliases read back their target register
    // ------------------------------------------------------------------
    always_comb begin
        rdata = '0;
        case (dec.sel)
            SEL_DATA:  rdata = 32'(filt);
            SEL_OUT:   rdata = 32'(out_q);
            SEL_DIR:   rdata = 32'(dir_q);
            SEL_IMASK: rdata = 32'(imask_q);
            SEL_IPOL:  rdata = 32'(ipol_q);
            SEL_IEDGE: rdata = 32'(iedge_q);
            SEL_IFLAG: rdata = 32'(iflag_q);
            SEL_DBCNT: rdata = 32'(dbcnt_q);
            default:   rdata = '0;
        endcase
    end

    assign apb_prdata  = (access && !apb_pwrite && mapped) ? rdata : 32'h0;
    assign apb_pready  = 1'b1;
    assign apb_pslverr = access & ~mapped;

    // DIR=1 means drive; reset leaves every driver off whatever OEPOL is
    assign gpio_dout = out_q;
    assign gpio_oen  = OEPOL ? dir_q : ~dir_q;
    assign irq       = irq_q;

endmodule
